// File: rtl/mips16_alu_pkg.sv
// Shared definitions for the MIPS16 ALU / multiply-divide core: operation
// select codes, default widths and the sequencer state encoding.
package mips16_alu_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int NITER_DEFAULT = 16;
  localparam int CNT_W         = 5;

  // Operation select codes, shared with alu_control
  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_MUL  = 4'b0010;
  localparam logic [3:0] SEL_DIV  = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_OR   = 4'b0101;
  localparam logic [3:0] SEL_SLT  = 4'b0110;
  localparam logic [3:0] SEL_BEQ  = 4'b1000;
  localparam logic [3:0] SEL_SLTI = 4'b1001;
  localparam logic [3:0] SEL_ADDI = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath. The accumulator/remainder and the
// multiplier/quotient shift register share storage: {acc_reg, shf_reg}.
// Multiply: shift-add, one partial product per step (LSB-first).
// Divide: restoring, one quotient bit per step (MSB-first).
// lo_next/hi_next expose the value the next step will store, so the
// controller can capture the final result on the same edge.
module alu_muldiv_iter
  import mips16_alu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int NITER = NITER_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          is_div,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] lo_next,
  output logic [DW-1:0] hi_next,
  output logic          last
);

  logic [DW-1:0]    acc_reg;
  logic [DW-1:0]    shf_reg;
  logic [DW-1:0]    opb_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [DW:0]   mul_sum;
  logic [DW-1:0] mul_lo;
  logic [DW-1:0] mul_hi;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] sub_lo;
  logic          fits;
  logic [DW-1:0] div_lo;
  logic [DW-1:0] div_hi;

  // One step of shift-add multiply and of restoring divide, selected by mode
  always_comb begin
    mul_sum = {1'b0, acc_reg} + (shf_reg[0] ? {1'b0, opb_reg} : '0);
    mul_lo  = {mul_sum[0], shf_reg[DW-1:1]};
    mul_hi  = mul_sum[DW:1];

    // Shift the next dividend bit into the partial remainder; when the
    // divisor fits, the difference is below 2^DW so its low bits suffice.
    rem_sh  = {acc_reg, shf_reg[DW-1]};
    fits    = (rem_sh >= {1'b0, opb_reg});
    sub_lo  = rem_sh[DW-1:0] - opb_reg;
    div_hi  = fits ? sub_lo : rem_sh[DW-1:0];
    div_lo  = {shf_reg[DW-2:0], fits};

    lo_next = is_div ? div_lo : mul_lo;
    hi_next = is_div ? div_hi : mul_hi;
    last    = (cnt_reg == CNT_W'(NITER - 1));
  end

  // Operand latch on load, datapath update and step count on each iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      shf_reg <= '0;
      opb_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      acc_reg <= '0;
      shf_reg <= a;
      opb_reg <= b;
      cnt_reg <= '0;
    end else if (step) begin
      acc_reg <= hi_next;
      shf_reg <= lo_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_muldiv_core.sv
// MIPS16 ALU core: single-cycle arithmetic/logic ops plus iterative unsigned
// multiply and divide. The top holds the sequencer, the single-cycle ops and
// the registered outputs; iteration lives in alu_muldiv_iter.
module alu_muldiv_core
  import mips16_alu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int NITER = NITER_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic [DW-1:0] hi,
  output logic          zero,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  state_t        state_reg;
  logic [DW-1:0] result_reg;
  logic [DW-1:0] hi_reg;
  logic          zero_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          dbz_reg;

  logic          accept;
  logic          b_is_zero;
  logic          iter_load;
  logic [DW-1:0] iter_lo;
  logic [DW-1:0] iter_hi;
  logic          iter_last;
  logic [DW-1:0] alu_res;
  logic          alu_zero;

  assign result = result_reg;
  assign hi     = hi_reg;
  assign zero   = zero_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign dbz    = dbz_reg;

  // Start is only honoured while idle; mul and non-zero div hand off to the iterator
  always_comb begin
    accept    = start && (state_reg == ST_IDLE);
    b_is_zero = (b == '0);
    iter_load = accept && ((sel == SEL_MUL) || ((sel == SEL_DIV) && !b_is_zero));
  end

  // Single-cycle result and zero flag; unknown codes give 0 with zero set
  always_comb begin
    alu_res = '0;
    case (sel)
      SEL_ADD, SEL_ADDI: alu_res = a + b;
      SEL_SUB, SEL_BEQ:  alu_res = a - b;
      SEL_AND:           alu_res = a & b;
      SEL_OR:            alu_res = a | b;
      SEL_SLT, SEL_SLTI: alu_res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default:           alu_res = '0;
    endcase
    alu_zero = (sel == SEL_BEQ) ? (a == b) : (alu_res == '0);
  end

  alu_muldiv_iter #(
    .DW    (DW),
    .NITER (NITER)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_load),
    .step    (busy_reg),
    .is_div  (state_reg == ST_DIV),
    .a       (a),
    .b       (b),
    .lo_next (iter_lo),
    .hi_next (iter_hi),
    .last    (iter_last)
  );

  // Sequencer and output registers; done is a one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      hi_reg     <= '0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (sel == SEL_MUL) begin
              state_reg <= ST_MUL;
              busy_reg  <= 1'b1;
            end else if (sel == SEL_DIV) begin
              if (b_is_zero) begin
                // Divide by zero completes at once without iterating
                result_reg <= '1;
                hi_reg     <= a;
                zero_reg   <= 1'b0;
                dbz_reg    <= 1'b1;
                done_reg   <= 1'b1;
              end else begin
                state_reg <= ST_DIV;
                busy_reg  <= 1'b1;
              end
            end else begin
              result_reg <= alu_res;
              hi_reg     <= '0;
              zero_reg   <= alu_zero;
              dbz_reg    <= 1'b0;
              done_reg   <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_last) begin
            result_reg <= iter_lo;
            hi_reg     <= iter_hi;
            zero_reg   <= (iter_lo == '0);
            dbz_reg    <= 1'b0;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_core.sv
// Self-checking bench for alu_muldiv_core: directed corner cases followed
// by random operations compared against a plain-arithmetic reference model.
module tb_alu_muldiv_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [15:0] result;
  logic [15:0] hi;
  logic        zero;
  logic        busy;
  logic        done;
  logic        dbz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_core #(
    .DW    (16),
    .NITER (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sel    (sel),
    .a      (a),
    .b      (b),
    .result (result),
    .hi     (hi),
    .zero   (zero),
    .busy   (busy),
    .done   (done),
    .dbz    (dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what each operation must produce, from plain arithmetic
  task automatic model(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic [15:0] h,
                       output logic z, output logic d, output int lat);
    logic [31:0] p;
    r = 16'd0; h = 16'd0; d = 1'b0; lat = 1;
    case (s)
      4'b0000, 4'b1010: r = x + y;
      4'b0001, 4'b1000: r = x - y;
      4'b0010: begin p = 32'(x) * 32'(y); r = p[15:0]; h = p[31:16]; lat = 17; end
      4'b0011: begin
        if (y == 16'd0) begin r = 16'hFFFF; h = x; d = 1'b1; end
        else begin r = x / y; h = x % y; lat = 17; end
      end
      4'b0100: r = x & y;
      4'b0101: r = x | y;
      4'b0110, 4'b1001: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    z = (s == 4'b1000) ? (x == y) : (r == 16'd0);
  endtask

  // Issue one operation from a negedge, wait for done (bounded), check all outputs,
  // then check the done pulse drops and the outputs hold. poke issues starts mid-op.
  task automatic run_op(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y,
                        input bit poke, input string tag);
    logic [15:0] er, eh;
    logic ez, ed;
    int elat, cyc;
    bit not_busy;
    model(s, x, y, er, eh, ez, ed, elat);
    sel = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    not_busy = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) not_busy = 1'b1;
      start = poke;
      sel = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    $display("op %s sel=%b a=%h b=%h -> result=%h hi=%h zero=%b dbz=%b cycles=%0d",
             tag, s, x, y, result, hi, zero, dbz, cyc);
    check({tag, ".latency"}, 32'(cyc), 32'(elat));
    check({tag, ".result"}, {16'd0, result}, {16'd0, er});
    check({tag, ".hi"}, {16'd0, hi}, {16'd0, eh});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, ".dbz"}, {31'd0, dbz}, {31'd0, ed});
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    if (elat > 1) check({tag, ".busy_during"}, {31'd0, not_busy}, 32'd0);
    a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".hold"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset.result", {16'd0, result}, 32'd0);
    check("reset.hi", {16'd0, hi}, 32'd0);
    check("reset.flags", {26'd0, zero, busy, done, dbz, 2'b00}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0000, 16'h7FFF, 16'h0001, 1'b0, "add_wrap");
    run_op(4'b1000, 16'h1234, 16'h1234, 1'b0, "beq_eq");
    run_op(4'b0110, 16'hFFFF, 16'h0001, 1'b0, "slt_neg");
    run_op(4'b0010, 16'hFFFF, 16'hFFFF, 1'b1, "mul_max");
    run_op(4'b0011, 16'h0064, 16'h0007, 1'b1, "div_100_7");
    run_op(4'b0011, 16'h0064, 16'h0000, 1'b0, "div_by_zero");
    run_op(4'b0111, 16'hA5A5, 16'h5A5A, 1'b0, "sel_unused");
    run_op(4'b1001, 16'h0003, 16'hFFFE, 1'b0, "slti_pos");
    run_op(4'b0010, 16'h0000, 16'h1234, 1'b0, "mul_zero");

    // Back-to-back single-cycle ops: done every cycle
    sel = 4'b0000; a = 16'd3; b = 16'd4; start = 1'b1;
    @(negedge clk);
    $display("b2b add -> done=%b result=%h", done, result);
    check("b2b1.done", {31'd0, done}, 32'd1);
    check("b2b1.result", {16'd0, result}, 32'd7);
    sel = 4'b0100; a = 16'hF0F0; b = 16'hFF00;
    @(negedge clk);
    $display("b2b and -> done=%b result=%h", done, result);
    check("b2b2.done", {31'd0, done}, 32'd1);
    check("b2b2.result", {16'd0, result}, 32'h0000F000);
    sel = 4'b0001; a = 16'd2; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    $display("b2b sub -> done=%b result=%h", done, result);
    check("b2b3.done", {31'd0, done}, 32'd1);
    check("b2b3.result", {16'd0, result}, 32'h0000FFFD);
    @(negedge clk);

    // Reset in the middle of a multiply aborts it
    sel = 4'b0010; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("abort reset -> result=%h hi=%h zero=%b busy=%b done=%b dbz=%b",
             result, hi, zero, busy, done, dbz);
    check("abort.result", {16'd0, result}, 32'd0);
    check("abort.hi", {16'd0, hi}, 32'd0);
    check("abort.flags", {28'd0, zero, busy, done, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("abort.no_done", {30'd0, done, busy}, 32'd0);
    end
    run_op(4'b0101, 16'h00F0, 16'h000F, 1'b0, "or_after_reset");

    // Random operations across all select codes, with occasional zero divisors
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rs;
      logic [15:0] rx, ry;
      rs = 4'($urandom_range(0, 15));
      rx = 16'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      run_op(rs, rx, ry, 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
